alu_result_buffer: RTL and testbench

Downstream stage of the ALU: captures every `out_valid`/`out_number` result the ALU produces into a 4-entry FIFO and re-issues it through a ready/valid handshake to the result consumer (checker or output serializer), which may stall. It also keeps running result statistics (count, max, min) and a sticky overflow flag for results lost while the buffer was full. The ALU has no back-pressure, so the block never stalls its input side; it only drops and flags.

---
 rtl/alu_result_buffer.sv | 110 +++++++++++
 tb/tb_alu_result_buffer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - 4-entry result FIFO with ready/valid egress and running statistics
// Input side never stalls: a result arriving while full (and not freed by a same-cycle pop) is dropped and flagged.
module alu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 10,
  parameter int CNTW  = 9,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_number_i,
  input  logic          out_ready_i,
  input  logic          stats_clr_i,
  output logic          out_valid_o,
  output logic [DW-1:0] out_number_o,
  output logic          full_o,
  output logic [LW-1:0] level_o,
  output logic          overflow_o,
  output logic [CNTW-1:0] res_count_o,
  output logic [DW-1:0] res_max_o,
  output logic [DW-1:0] res_min_o
);

  logic [DW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [CNTW-1:0] res_count_q, res_count_d;
  logic [DW-1:0]   res_max_q, res_max_d;
  logic [DW-1:0]   res_min_q, res_min_d;

  logic pop, push, drop;

  assign out_valid_o  = (level_q != '0);
  assign full_o       = (level_q == LW'(DEPTH));
  assign out_number_o = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o      = level_q;
  assign overflow_o   = overflow_q;
  assign res_count_o  = res_count_q;
  assign res_max_o    = res_max_q;
  assign res_min_o    = res_min_q;

  // A pop at full frees the slot in the same cycle, so out_ready feeds push.
  assign pop  = out_valid_o & out_ready_i;
  assign push = in_valid_i & (~full_o | pop);
  assign drop = in_valid_i & full_o & ~pop;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    res_count_d = res_count_q;
    res_max_d   = res_max_q;
    res_min_d   = res_min_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Clear first, then fold in this cycle's push or drop.
    if (stats_clr_i) begin
      overflow_d  = 1'b0;
      res_count_d = '0;
      res_max_d   = '0;
      res_min_d   = '1;
    end

    if (push) begin
      if (res_count_d != '1) res_count_d = res_count_d + CNTW'(1);
      if (in_number_i > res_max_d) res_max_d = in_number_i;
      if (in_number_i < res_min_d) res_min_d = in_number_i;
    end

    if (drop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      res_count_q <= '0;
      res_max_q   <= '0;
      res_min_q   <= '1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      res_count_q <= res_count_d;
      res_max_q   <= res_max_d;
      res_min_q   <= res_min_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem_q[wr_ptr_q] <= in_number_i;
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - directed scoreboard bench for alu_result_buffer
module tb_alu_result_buffer;

  localparam int DEPTH = 4;
  localparam int DW    = 10;
  localparam int CNTW  = 9;

  logic          clk = 1'b0;
  logic          rst, in_valid, out_ready, stats_clr;
  logic [DW-1:0] in_number;
  logic          out_valid, full, overflow;
  logic [DW-1:0] out_number, res_max, res_min;
  logic [2:0]    level;
  logic [CNTW-1:0] res_count;

  int checks = 0;
  int failures = 0;

  int q[$];
  int m_cnt, m_max, m_min, m_ov;

  always #5 clk = ~clk;

  alu_result_buffer #(.DEPTH(DEPTH), .DW(DW), .CNTW(CNTW)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_number_i(in_number),
    .out_ready_i(out_ready), .stats_clr_i(stats_clr),
    .out_valid_o(out_valid), .out_number_o(out_number), .full_o(full),
    .level_o(level), .overflow_o(overflow), .res_count_o(res_count),
    .res_max_o(res_max), .res_min_o(res_min)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("out_valid", 32'(out_valid), (q.size() != 0));
    chk("out_number", 32'(out_number), (q.size() != 0) ? q[0] : 0);
    chk("full", 32'(full), (q.size() == DEPTH));
    chk("level", 32'(level), q.size());
    chk("overflow", 32'(overflow), m_ov);
    chk("res_count", 32'(res_count), m_cnt);
    chk("res_max", 32'(res_max), m_max);
    chk("res_min", 32'(res_min), m_min);
  endtask

  // Drive one cycle of inputs, advance the scoreboard, clock, then compare.
  task automatic step(input logic r, input logic v, input int n, input logic rdy, input logic clr);
    bit pop_m, push_m, drop_m;
    rst = r; in_valid = v; in_number = DW'(n); out_ready = rdy; stats_clr = clr;
    pop_m  = (q.size() != 0) && rdy;
    push_m = v && ((q.size() != DEPTH) || pop_m);
    drop_m = v && (q.size() == DEPTH) && !pop_m;
    if (r) begin
      q.delete();
      m_cnt = 0; m_max = 0; m_min = (1 << DW) - 1; m_ov = 0;
    end else begin
      if (pop_m) begin
        chk("pop_value", 32'(out_number), q[0]);
        void'(q.pop_front());
      end
      if (clr) begin
        m_cnt = 0; m_max = 0; m_min = (1 << DW) - 1; m_ov = 0;
      end
      if (push_m) begin
        q.push_back(n % (1 << DW));
        if (m_cnt != (1 << CNTW) - 1) m_cnt++;
        if ((n % (1 << DW)) > m_max) m_max = n % (1 << DW);
        if ((n % (1 << DW)) < m_min) m_min = n % (1 << DW);
      end
      if (drop_m) m_ov = 1;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_number = '0; out_ready = 1'b0; stats_clr = 1'b0;
    m_cnt = 0; m_max = 0; m_min = 1023; m_ov = 0;

    // reset
    step(1, 0, 0, 0, 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_min", 32'(res_min), 1023);

    // push 7, 3, 20 with consumer stalled
    step(0, 1, 7, 0, 0);
    step(0, 1, 3, 0, 0);
    step(0, 1, 20, 0, 0);
    chk("tp1_level", 32'(level), 3);
    chk("tp1_head", 32'(out_number), 7);
    chk("tp1_count", 32'(res_count), 3);
    chk("tp1_max", 32'(res_max), 20);
    chk("tp1_min", 32'(res_min), 3);
    step(0, 0, 0, 0, 0);
    chk("tp1_hold", 32'(out_number), 7);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    chk("tp1_empty", 32'(out_valid), 0);

    // fill with 1..5 while stalled: fifth dropped
    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 5; i++) step(0, 1, i, 0, 0);
    chk("tp2_full", 32'(full), 1);
    chk("tp2_overflow", 32'(overflow), 1);
    chk("tp2_count", 32'(res_count), 4);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    chk("tp2_drained", 32'(out_valid), 0);

    // push and pop together at full
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 100 + i, 0, 0);
    step(0, 1, 9, 1, 0);
    chk("tp3_level", 32'(level), 4);
    chk("tp3_overflow", 32'(overflow), 0);
    chk("tp3_head", 32'(out_number), 101);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);

    // 299 back-to-back results with continuous ready
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 299; i++) step(0, 1, i % 1024, 1, 0);
    chk("tp4_count", 32'(res_count), 299);
    chk("tp4_max", 32'(res_max), 298);
    step(0, 0, 0, 1, 0);
    chk("tp4_empty", 32'(out_valid), 0);

    // clear with simultaneous push; clear with simultaneous drop
    for (int i = 0; i < 3; i++) step(0, 1, 50 + i, 0, 0);
    step(0, 1, 99, 0, 0);
    step(0, 1, 77, 0, 0);
    chk("tp5_pre_ov", 32'(overflow), 1);
    step(0, 0, 0, 1, 0);
    step(0, 1, 12, 0, 1);
    chk("tp5_count", 32'(res_count), 1);
    chk("tp5_max", 32'(res_max), 12);
    chk("tp5_min", 32'(res_min), 12);
    chk("tp5_overflow", 32'(overflow), 0);
    chk("tp5_level", 32'(level), 4);
    step(0, 1, 33, 0, 1);
    chk("clr_drop_ov", 32'(overflow), 1);
    chk("clr_drop_count", 32'(res_count), 0);

    // reset mid-burst with level 3 and overflow set
    step(0, 0, 0, 1, 0);
    chk("tp6_pre_level", 32'(level), 3);
    step(1, 1, 44, 1, 0);
    chk("tp6_level", 32'(level), 0);
    chk("tp6_ov", 32'(overflow), 0);
    chk("tp6_min", 32'(res_min), 1023);
    step(0, 1, 8, 0, 0);
    chk("tp6_out", 32'(out_number), 8);
    step(0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
